nanorisc_mc_control: RTL and testbench

Multi-cycle, parametrised control unit for the NanoRisc core. It replaces single-cycle opcode decoding with a registered state machine that sequences fetch, decode, execute, memory/send wait and writeback. It handshakes with instruction memory, data memory and the send port, and supports halt/resume, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register/fetch logic and the datapath (PC, register file, ULA, data memory).

---
 rtl/nanorisc_mc_control.sv | 171 +++++++++++++++++
 tb/tb_nanorisc_mc_control.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nanorisc_mc_control.sv
// Multi-cycle control unit for the NanoRisc core: sequences fetch, decode, execute,
// memory/send wait and writeback, with halt/resume, illegal-opcode trap and retire count.
module nanorisc_mc_control #(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned ULAOP_W  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                send_ready,
  input  logic                resume,
  output logic                fetch_req,
  output logic                PCWrite,
  output logic                isBranch,
  output logic                branch_taken,
  output logic [ULAOP_W-1:0]  ULAOp,
  output logic                RegWrite,
  output logic                RegMemWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                isSend,
  output logic                halted,
  output logic                illegal_op,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StSend   = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StHalted = 3'd6;

  localparam logic [2:0] OpSum  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpMul  = 3'd2;
  localparam logic [2:0] OpLwi  = 3'd3;
  localparam logic [2:0] OpSwi  = 3'd4;
  localparam logic [2:0] OpBne  = 3'd5;
  localparam logic [2:0] OpSend = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [2:0]          op3;
  logic                op_hi;
  logic [1:0]          ula;

  assign op3 = op_q[2:0];

  // Any set bit above the three defined opcode bits marks the opcode illegal.
  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign op_hi = |op_q[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign op_hi = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      StFetch: begin
        if (instr_valid) begin
          op_d    = opcode;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op_hi) begin
          illegal_d = 1'b1;
          state_d   = StHalted;
        end else begin
          case (op3)
            OpSum, OpSub, OpMul, OpBne: state_d = StExec;
            OpLwi, OpSwi:               state_d = StMem;
            OpSend:                     state_d = StSend;
            default: begin
              // halt retires on entry to HALTED; illegal opcodes never do
              state_d   = StHalted;
              retired_d = retired_q + CNT_W'(1);
            end
          endcase
        end
      end
      StExec: begin
        zero_d  = zero;
        state_d = StWb;
      end
      StMem:    if (mem_ready) state_d = StWb;
      StSend:   if (send_ready) state_d = StWb;
      StWb: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = StFetch;
      end
      StHalted: if (resume && !illegal_q) state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      op_q      <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    fetch_req    = (state_q == StFetch);
    halted       = (state_q == StHalted);
    PCWrite      = 1'b0;
    isBranch     = 1'b0;
    branch_taken = 1'b0;
    RegWrite     = 1'b0;
    RegMemWrite  = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    isSend       = 1'b0;
    ula          = 2'd0;
    if ((state_q == StExec || state_q == StWb) && !op_hi) begin
      case (op3)
        OpSub, OpBne: ula = 2'd1;
        OpMul:        ula = 2'd2;
        default:      ula = 2'd0;
      endcase
    end
    case (state_q)
      StMem: begin
        MemRead  = (op3 == OpLwi);
        MemWrite = (op3 == OpSwi);
      end
      StSend: isSend = 1'b1;
      StWb: begin
        PCWrite      = 1'b1;
        RegWrite     = (op3 == OpSum) || (op3 == OpSub) || (op3 == OpMul) || (op3 == OpSend);
        RegMemWrite  = (op3 == OpLwi);
        isBranch     = (op3 == OpBne);
        branch_taken = (op3 == OpBne) && !zero_q;
        isSend       = (op3 == OpSend);
      end
      default: ;
    endcase
    ULAOp = ULAOP_W'(ula);
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_nanorisc_mc_control.sv
// Self-checking bench: two parameterisations driven in lockstep and compared every cycle
// against a per-instruction trace model of the control sequence.
module tb_nanorisc_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       instr_valid, zero, mem_ready, send_ready, resume;

  logic        a_fetch_req, a_PCWrite, a_isBranch, a_branch_taken, a_RegWrite, a_RegMemWrite;
  logic        a_MemRead, a_MemWrite, a_isSend, a_halted, a_illegal_op;
  logic [1:0]  a_ULAOp;
  logic [2:0]  a_state;
  logic [15:0] a_retired;

  logic        b_fetch_req, b_PCWrite, b_isBranch, b_branch_taken, b_RegWrite, b_RegMemWrite;
  logic        b_MemRead, b_MemWrite, b_isSend, b_halted, b_illegal_op;
  logic [2:0]  b_ULAOp;
  logic [2:0]  b_state;
  logic [1:0]  b_retired;

  always #5 clk = ~clk;

  nanorisc_mc_control #(.OPCODE_W(3), .ULAOP_W(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode[2:0]), .instr_valid(instr_valid), .zero(zero),
    .mem_ready(mem_ready), .send_ready(send_ready), .resume(resume),
    .fetch_req(a_fetch_req), .PCWrite(a_PCWrite), .isBranch(a_isBranch),
    .branch_taken(a_branch_taken), .ULAOp(a_ULAOp), .RegWrite(a_RegWrite),
    .RegMemWrite(a_RegMemWrite), .MemRead(a_MemRead), .MemWrite(a_MemWrite),
    .isSend(a_isSend), .halted(a_halted), .illegal_op(a_illegal_op), .state(a_state),
    .retired(a_retired)
  );

  nanorisc_mc_control #(.OPCODE_W(4), .ULAOP_W(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instr_valid), .zero(zero),
    .mem_ready(mem_ready), .send_ready(send_ready), .resume(resume),
    .fetch_req(b_fetch_req), .PCWrite(b_PCWrite), .isBranch(b_isBranch),
    .branch_taken(b_branch_taken), .ULAOp(b_ULAOp), .RegWrite(b_RegWrite),
    .RegMemWrite(b_RegMemWrite), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .isSend(b_isSend), .halted(b_halted), .illegal_op(b_illegal_op), .state(b_state),
    .retired(b_retired)
  );

  int          n_vec, n_err;
  int unsigned cnt;
  logic        ill_m, chk_a;
  logic [2:0]  e_state, e_ula;
  logic        e_fetch, e_pcw, e_isb, e_bt, e_rw, e_rmw, e_mr, e_mw, e_snd, e_hlt, e_ill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_clear();
    e_state = 3'd0; e_ula = 3'd0;
    e_fetch = 0; e_pcw = 0; e_isb = 0; e_bt = 0; e_rw = 0; e_rmw = 0;
    e_mr = 0; e_mw = 0; e_snd = 0; e_hlt = 0; e_ill = ill_m;
  endtask

  task automatic check_cycle(input string tag);
    logic [16:0] exp_v;
    logic [1:0]  cnt_b;
    logic [15:0] cnt_a;
    exp_v = {e_state, e_ula, e_fetch, e_pcw, e_isb, e_bt, e_rw, e_rmw, e_mr, e_mw, e_snd, e_hlt,
             e_ill};
    cnt_b = cnt[1:0];
    cnt_a = cnt[15:0];
    check_eq({tag, "/b"}, 32'({b_state, b_ULAOp, b_fetch_req, b_PCWrite, b_isBranch,
             b_branch_taken, b_RegWrite, b_RegMemWrite, b_MemRead, b_MemWrite, b_isSend,
             b_halted, b_illegal_op}), 32'(exp_v));
    check_eq({tag, "/b.retired"}, 32'(b_retired), 32'(cnt_b));
    if (chk_a) begin
      check_eq({tag, "/a"}, 32'({a_state, 1'b0, a_ULAOp, a_fetch_req, a_PCWrite, a_isBranch,
               a_branch_taken, a_RegWrite, a_RegMemWrite, a_MemRead, a_MemWrite, a_isSend,
               a_halted, a_illegal_op}), 32'(exp_v));
      check_eq({tag, "/a.retired"}, 32'(a_retired), 32'(cnt_a));
    end
  endtask

  // Advance to the next sampling point and scramble every input; callers then
  // override the ones the current phase actually listens to.
  task automatic cyc();
    @(negedge clk);
    opcode      = 4'($urandom);
    instr_valid = 1'($urandom);
    zero        = 1'($urandom);
    mem_ready   = 1'($urandom);
    send_ready  = 1'($urandom);
    resume      = 1'($urandom);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    instr_valid = 1'b0;
    #1;
    ill_m = 1'b0;
    cnt = 0;
    exp_clear(); e_fetch = 1'b1;
    check_cycle(tag);
    @(negedge clk);
    exp_clear(); e_fetch = 1'b1;
    check_cycle({tag, ".hold"});
    instr_valid = 1'b0;
    reset = 1'b0;
  endtask

  // One instruction from FETCH through WB (or into HALTED). w = wait cycles in MEM/SEND,
  // hold = extra HALTED cycles before resume, abort = MEM cycle index to reset at (-1: none).
  task automatic run_instr(input logic [3:0] op, input logic z, input int w, input int hold,
                           input int abort);
    logic [2:0] u;
    int idle;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      cyc(); exp_clear(); e_fetch = 1'b1; check_cycle("fetch_idle");
      instr_valid = 1'b0;
    end
    cyc(); exp_clear(); e_fetch = 1'b1; check_cycle("fetch");
    instr_valid = 1'b1; opcode = op;
    cyc(); exp_clear(); e_state = 3'd1; check_cycle("decode");
    if (op > 4'd7) begin
      ill_m = 1'b1;
      for (int i = 0; i <= hold; i++) begin
        cyc(); exp_clear(); e_state = 3'd6; e_hlt = 1'b1; check_cycle("illegal_halt");
        resume = 1'b1;
      end
      return;
    end
    case (op)
      4'd0, 4'd1, 4'd2, 4'd5: begin
        u = (op == 4'd2) ? 3'd2 : (op == 4'd0) ? 3'd0 : 3'd1;
        cyc(); exp_clear(); e_state = 3'd2; e_ula = u; check_cycle("exec");
        zero = z;
        cyc(); exp_clear(); e_state = 3'd5; e_ula = u; e_pcw = 1'b1;
        e_rw = (op != 4'd5); e_isb = (op == 4'd5); e_bt = (op == 4'd5) && !z;
        check_cycle("wb_alu");
        cnt++;
      end
      4'd3, 4'd4: begin
        for (int i = 0; i <= w; i++) begin
          cyc(); exp_clear(); e_state = 3'd3; e_mr = (op == 4'd3); e_mw = (op == 4'd4);
          check_cycle("mem_wait");
          if (i == abort) begin
            do_reset("reset_mid_mem");
            return;
          end
          mem_ready = (i == w);
        end
        cyc(); exp_clear(); e_state = 3'd5; e_pcw = 1'b1; e_rmw = (op == 4'd3);
        check_cycle("wb_mem");
        cnt++;
      end
      4'd7: begin
        for (int i = 0; i <= w; i++) begin
          cyc(); exp_clear(); e_state = 3'd4; e_snd = 1'b1; check_cycle("send_wait");
          send_ready = (i == w);
        end
        cyc(); exp_clear(); e_state = 3'd5; e_pcw = 1'b1; e_rw = 1'b1; e_snd = 1'b1;
        check_cycle("wb_send");
        cnt++;
      end
      default: begin
        cnt++;
        for (int i = 0; i <= hold; i++) begin
          cyc(); exp_clear(); e_state = 3'd6; e_hlt = 1'b1; check_cycle("halted");
          resume = (i == hold);
        end
      end
    endcase
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_a = 1'b1; ill_m = 1'b0; cnt = 0;
    opcode = '0; instr_valid = 0; zero = 0; mem_ready = 0; send_ready = 0; resume = 0;
    do_reset("reset");

    run_instr(4'd0, 1'b0, 0, 0, -1);   // sum
    run_instr(4'd5, 1'b0, 0, 0, -1);   // bne taken
    run_instr(4'd5, 1'b1, 0, 0, -1);   // bne not taken
    run_instr(4'd3, 1'b0, 3, 0, -1);   // lwi, 3 stall cycles
    run_instr(4'd4, 1'b0, 3, 0, -1);   // swi, 3 stall cycles
    run_instr(4'd7, 1'b0, 2, 0, -1);   // send, 2 stall cycles
    run_instr(4'd6, 1'b0, 0, 9, -1);   // halt for 10 cycles, then resume
    run_instr(4'd1, 1'b0, 0, 0, -1);
    run_instr(4'd2, 1'b1, 0, 0, -1);

    do_reset("reset_wrap");
    for (int i = 0; i < 5; i++) run_instr(4'd0, 1'b0, 0, 0, -1);

    for (int i = 0; i < 150; i++)
      run_instr(4'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), -1);

    chk_a = 1'b0;
    run_instr(4'b1001, 1'b0, 0, 5, -1);
    chk_a = 1'b1;
    do_reset("reset_after_illegal");

    run_instr(4'd3, 1'b0, 3, 0, 1);
    run_instr(4'd0, 1'b0, 0, 0, -1);
    cyc(); exp_clear(); e_fetch = 1'b1; check_cycle("final_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
